// File: rtl/branch_predictor_sa.sv
// Set-associative branch predictor: 2-bit counters, LRU ages, zero-latency lookup.
// Optional statistics counters are enabled by defining BP_STATS_EN.
`ifndef XLEN
`define XLEN 32
`endif

module branch_predictor_sa #(
    parameter int unsigned SETS = 16,
    parameter int unsigned WAYS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_valid,
    input  logic [`XLEN-1:0]  fetch_pc,
    output logic              predict_hit,
    output logic              predict_direction,
    output logic [`XLEN-1:0]  predict_pc,
`ifdef BP_STATS_EN
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_updates,
    output logic [31:0]       stat_mispredicts,
`endif
    input  logic              update_valid,
    input  logic [`XLEN-1:0]  update_pc,
    input  logic              update_direction,
    input  logic [`XLEN-1:0]  update_target,
    input  logic              update_mispredict
);
    localparam int unsigned XW = `XLEN;
    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned AW = $clog2(WAYS);
    localparam int unsigned TW = XW - 2 - IW;

    typedef enum logic [1:0] {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T} ctr_t;

    logic          valid_q  [SETS][WAYS];
    logic [TW-1:0] tag_q    [SETS][WAYS];
    ctr_t          ctr_q    [SETS][WAYS];
    logic [XW-1:0] target_q [SETS][WAYS];
    logic [AW-1:0] age_q    [SETS][WAYS];

    logic [IW-1:0] f_idx, u_idx;
    logic [TW-1:0] f_tag, u_tag;
    assign f_idx = fetch_pc[2 +: IW];
    assign u_idx = update_pc[2 +: IW];
    assign f_tag = fetch_pc[XW-1 -: TW];
    assign u_tag = update_pc[XW-1 -: TW];

    logic          f_hit;
    logic [AW-1:0] f_way;
    logic [AW-1:0] f_age_nxt [WAYS];

    always_comb begin
        f_hit = 1'b0;
        f_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag) begin
                f_hit = 1'b1;
                f_way = AW'(w);
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            f_age_nxt[w] = age_q[f_idx][w];
            if (fetch_valid && f_hit) begin
                if (AW'(w) == f_way)
                    f_age_nxt[w] = '0;
                else if (age_q[f_idx][w] < age_q[f_idx][f_way])
                    f_age_nxt[w] = age_q[f_idx][w] + AW'(1);
            end
        end
    end

    assign predict_hit       = f_hit;
    assign predict_direction = f_hit && ctr_q[f_idx][f_way][1];
    assign predict_pc        = predict_direction ? target_q[f_idx][f_way] : fetch_pc + XW'(4);

    logic          u_hit, u_inv_found, u_touch;
    logic [AW-1:0] u_hit_way, u_inv_way, u_old_way, u_way;
    logic [AW-1:0] u_base    [WAYS];
    logic [AW-1:0] u_age_nxt [WAYS];
    ctr_t          u_ctr_nxt;

    // The update sees ages after the same-cycle fetch touch, so the update way ends MRU.
    always_comb begin
        u_hit       = 1'b0;
        u_hit_way   = '0;
        u_inv_found = 1'b0;
        u_inv_way   = '0;
        u_old_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            u_base[w] = (u_idx == f_idx) ? f_age_nxt[w] : age_q[u_idx][w];
            if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
                u_hit     = 1'b1;
                u_hit_way = AW'(w);
            end
        end
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!valid_q[u_idx][WAYS-1-i]) begin
                u_inv_found = 1'b1;
                u_inv_way   = AW'(WAYS-1-i);
            end
            if (u_base[i] == AW'(WAYS-1))
                u_old_way = AW'(i);
        end
        u_way   = u_hit ? u_hit_way : (u_inv_found ? u_inv_way : u_old_way);
        u_touch = update_valid && (u_hit || update_direction);
        for (int unsigned w = 0; w < WAYS; w++) begin
            u_age_nxt[w] = u_base[w];
            if (AW'(w) == u_way)
                u_age_nxt[w] = '0;
            else if (u_base[w] < u_base[u_way])
                u_age_nxt[w] = u_base[w] + AW'(1);
        end
        u_ctr_nxt = ctr_q[u_idx][u_way];
        unique case (ctr_q[u_idx][u_way])
            STRONG_NT: u_ctr_nxt = update_direction ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   u_ctr_nxt = update_direction ? WEAK_T   : STRONG_NT;
            WEAK_T:    u_ctr_nxt = update_direction ? STRONG_T : WEAK_NT;
            STRONG_T:  u_ctr_nxt = update_direction ? STRONG_T : WEAK_T;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    ctr_q[s][w]    <= STRONG_NT;
                    target_q[s][w] <= '0;
                    age_q[s][w]    <= AW'(w);
                end
            end
        end else begin
            if (fetch_valid && f_hit) begin
                for (int unsigned w = 0; w < WAYS; w++)
                    age_q[f_idx][w] <= f_age_nxt[w];
            end
            if (u_touch) begin
                for (int unsigned w = 0; w < WAYS; w++)
                    age_q[u_idx][w] <= u_age_nxt[w];
                if (u_hit) begin
                    ctr_q[u_idx][u_way] <= u_ctr_nxt;
                    if (update_direction)
                        target_q[u_idx][u_way] <= update_target;
                end else begin
                    valid_q[u_idx][u_way]  <= 1'b1;
                    tag_q[u_idx][u_way]    <= u_tag;
                    ctr_q[u_idx][u_way]    <= WEAK_T;
                    target_q[u_idx][u_way] <= update_target;
                end
            end
        end
    end

`ifdef BP_STATS_EN
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_lookups     <= '0;
            stat_hits        <= '0;
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (fetch_valid && stat_lookups != '1)
                stat_lookups <= stat_lookups + 32'd1;
            if (fetch_valid && predict_hit && stat_hits != '1)
                stat_hits <= stat_hits + 32'd1;
            if (update_valid && stat_updates != '1)
                stat_updates <= stat_updates + 32'd1;
            if (update_valid && update_mispredict && stat_mispredicts != '1)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0], update_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor_sa.sv
// Scoreboard bench for branch_predictor_sa (default SETS=16, WAYS=4).
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif

module tb_branch_predictor_sa;
    localparam int unsigned XW = `XLEN;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_valid = 1'b0;
    logic [XW-1:0] fetch_pc = '0;
    logic          predict_hit, predict_direction;
    logic [XW-1:0] predict_pc;
    logic          update_valid = 1'b0;
    logic [XW-1:0] update_pc = '0;
    logic          update_direction = 1'b0;
    logic [XW-1:0] update_target = '0;
    logic          update_mispredict = 1'b0;
`ifdef BP_STATS_EN
    logic [31:0]   stat_lookups, stat_hits, stat_updates, stat_mispredicts;
`endif

    branch_predictor_sa #(.SETS(16), .WAYS(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .predict_hit       (predict_hit),
        .predict_direction (predict_direction),
        .predict_pc        (predict_pc),
`ifdef BP_STATS_EN
        .stat_lookups      (stat_lookups),
        .stat_hits         (stat_hits),
        .stat_updates      (stat_updates),
        .stat_mispredicts  (stat_mispredicts),
`endif
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_direction  (update_direction),
        .update_target     (update_target),
        .update_mispredict (update_mispredict)
    );

    always #5 clock = ~clock;

    typedef struct {
        string         tag;
        logic          hit;
        logic          dir;
        logic [XW-1:0] pc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic expect_pred(input string tag, input logic hit, input logic dir, input logic [XW-1:0] pc);
        exp_t e;
        e.tag = tag; e.hit = hit; e.dir = dir; e.pc = pc;
        sb.push_back(e);
    endtask

    // One clock: drive at negedge, compare any queued expectation before the next posedge.
    task automatic cycle(input logic rst, input logic fv, input logic [XW-1:0] fpc,
                         input logic uv, input logic [XW-1:0] upc, input logic ud,
                         input logic [XW-1:0] ut, input logic um);
        exp_t e;
        @(negedge clock);
        reset = rst; fetch_valid = fv; fetch_pc = fpc;
        update_valid = uv; update_pc = upc; update_direction = ud;
        update_target = ut; update_mispredict = um;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({e.tag, ".hit"}, 64'(predict_hit), 64'(e.hit));
            check_eq({e.tag, ".dir"}, 64'(predict_direction), 64'(e.dir));
            check_eq({e.tag, ".pc"},  64'(predict_pc), 64'(e.pc));
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic upd(input logic [XW-1:0] pc, input logic dir, input logic [XW-1:0] tgt);
        cycle(1'b0, 1'b0, '0, 1'b1, pc, dir, tgt, 1'b0);
    endtask

    task automatic probe(input string tag, input logic fv, input logic [XW-1:0] pc,
                         input logic hit, input logic dir, input logic [XW-1:0] ppc);
        expect_pred(tag, hit, dir, ppc);
        cycle(1'b0, fv, pc, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic fill_set0();
        upd(32'h000, 1'b1, 32'h1000);
        upd(32'h040, 1'b1, 32'h1040);
        upd(32'h080, 1'b1, 32'h1080);
        upd(32'h0C0, 1'b1, 32'h10C0);
    endtask

    initial begin
        // Reset state, and reset overriding concurrent fetch/update
        cycle(1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        probe("rst_miss", 1'b1, 32'h100, 1'b0, 1'b0, 32'h104);
        probe("rst_miss_b", 1'b0, 32'h7FC, 1'b0, 1'b0, 32'h800);

        // Same-cycle fetch + allocating update: old state predicted, new state next cycle
        expect_pred("same_cyc", 1'b0, 1'b0, 32'h104);
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0);
        probe("same_cyc_next", 1'b1, 32'h100, 1'b1, 1'b1, 32'h300);

        // Counter walk: NT updates must not touch the target; saturation at both ends
        do_reset();
        upd(32'h100, 1'b1, 32'h200);
        probe("alloc_hit", 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'hDEAD);
        probe("nt1", 1'b1, 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'hDEAD);
        upd(32'h100, 1'b0, 32'hDEAD);
        upd(32'h100, 1'b1, 32'h200);
        probe("sat_lo", 1'b1, 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h200);
        probe("retaken", 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);

        do_reset();
        for (int i = 0; i < 4; i++) upd(32'h100, 1'b1, 32'h400);
        upd(32'h100, 1'b0, 32'h0);
        probe("sat_hi_wt", 1'b1, 32'h100, 1'b1, 1'b1, 32'h400);
        upd(32'h100, 1'b0, 32'h0);
        probe("sat_hi_wnt", 1'b1, 32'h100, 1'b1, 1'b0, 32'h104);

        // Not-taken miss allocates nothing
        upd(32'h500, 1'b0, 32'h900);
        probe("nt_miss", 1'b1, 32'h500, 1'b0, 1'b0, 32'h504);

        // LRU replacement with a valid fetch touching 0x000
        do_reset();
        fill_set0();
        probe("touch0", 1'b1, 32'h000, 1'b1, 1'b1, 32'h1000);
        upd(32'h100, 1'b1, 32'h2100);
        probe("evict40", 1'b0, 32'h040, 1'b0, 1'b0, 32'h044);
        probe("keep00", 1'b0, 32'h000, 1'b1, 1'b1, 32'h1000);
        probe("keep80", 1'b0, 32'h080, 1'b1, 1'b1, 32'h1080);
        probe("new100", 1'b0, 32'h100, 1'b1, 1'b1, 32'h2100);
        probe("other_set", 1'b0, 32'h004, 1'b0, 1'b0, 32'h008);

        // Fetch without fetch_valid predicts but must not refresh LRU
        do_reset();
        fill_set0();
        probe("nofv_hit", 1'b0, 32'h000, 1'b1, 1'b1, 32'h1000);
        upd(32'h100, 1'b1, 32'h2100);
        probe("nofv_evict00", 1'b0, 32'h000, 1'b0, 1'b0, 32'h004);
        probe("nofv_keep40", 1'b0, 32'h040, 1'b1, 1'b1, 32'h1040);

        // Same-set fetch and update hit in one cycle: both touched, oldest becomes 0x080
        do_reset();
        fill_set0();
        cycle(1'b0, 1'b1, 32'h000, 1'b1, 32'h040, 1'b1, 32'h1040, 1'b0);
        upd(32'h100, 1'b1, 32'h2100);
        probe("dual_evict80", 1'b0, 32'h080, 1'b0, 1'b0, 32'h084);
        probe("dual_keepC0", 1'b0, 32'h0C0, 1'b1, 1'b1, 32'h10C0);

`ifdef BP_STATS_EN
        do_reset();
        cycle(1'b0, 1'b1, 32'h100, 1'b0, '0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 1'b0, '0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        check_eq("stat_lookups", 64'(stat_lookups), 64'd3);
        check_eq("stat_hits", 64'(stat_hits), 64'd1);
        check_eq("stat_updates", 64'(stat_updates), 64'd2);
        check_eq("stat_mispredicts", 64'(stat_mispredicts), 64'd1);
        do_reset();
        check_eq("stat_clear", 64'({stat_lookups, stat_hits} | {stat_updates, stat_mispredicts}), 64'd0);
`endif

        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_predictor_sa.md
BRANCH_PREDICTOR_SA -- requirements
Module: branch_predictor_sa

Interface
REQ-001 SHALL have parameter SETS, default 16, meaning number of sets; power of two, 2..256.
REQ-002 SHALL have parameter WAYS, default 4, meaning ways per set; power of two, 2..8.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fetch_valid  input  1  lookup request this cycle.
REQ-006 SHALL have port fetch_pc  input  `XLEN  PC being fetched.
REQ-007 SHALL have port predict_hit  output  1  fetch_pc matches a valid entry.
REQ-008 SHALL have port predict_direction  output  1  predicted taken.
REQ-009 SHALL have port predict_pc  output  `XLEN  predicted next PC.
REQ-010 SHALL have port update_valid  input  1  resolved branch from branch FU.
REQ-011 SHALL have port update_pc  input  `XLEN  resolved branch PC.
REQ-012 SHALL have port update_direction  input  1  actual outcome, 1 = taken.
REQ-013 SHALL have port update_target  input  `XLEN  actual taken target.
REQ-014 SHALL have port update_mispredict  input  1  FU detected misprediction; used only by statistics.

Function
REQ-015 SHALL use index = pc[2 +: log2(SETS)] and tag = pc[`XLEN-1 : 2+log2(SETS)]; each entry holds valid, tag, 2-bit counter (STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3), target, log2(WAYS)-bit age.
REQ-016 SHALL produce predictions combinationally from registered state, zero-cycle latency; outputs are valid regardless of fetch_valid.
REQ-017 On hit: predict_hit=1, predict_direction = counter[1], predict_pc = target if taken, else fetch_pc+4.
REQ-018 On miss: predict_hit=0, predict_direction=0, predict_pc = fetch_pc+4.
REQ-019 Fetch with fetch_valid=1 and hit SHALL make the hit way MRU (age 0); ways younger than it age by 1; others unchanged.
REQ-020 Update hit: counter saturating +1 if taken, -1 if not taken; target := update_target only if taken; way made MRU.
REQ-021 Update miss with update_direction=1 SHALL allocate: victim = lowest-index invalid way, otherwise the way with age WAYS-1; write tag, target, counter=WEAK_T, valid=1; make it MRU.
REQ-022 Update miss with update_direction=0 SHALL change no state.
REQ-023 Ages within each set SHALL always be a permutation of 0..WAYS-1.
REQ-024 Fetch and update in the same set, same cycle: fetch touch applied first, then update touch; update way ends MRU.
REQ-025 Update and fetch on the same PC, same cycle: prediction uses pre-update state; update visible next cycle.
REQ-026 Sets other than the fetch/update index SHALL remain unchanged.

Reset
REQ-027 While reset=1 at a clock edge: all valid=0, counters=STRONG_NT, tags=0, targets=0, age of way w = w in every set.
REQ-028 After reset, outputs SHALL be predict_hit=0, predict_direction=0, predict_pc=fetch_pc+4.
REQ-029 Reset asserted with fetch_valid or update_valid high SHALL override them; no allocation or update occurs.

Configuration
REQ-030 With macro BP_STATS_EN defined, SHALL add 32-bit outputs stat_lookups, stat_hits, stat_updates, stat_mispredicts, incremented respectively on fetch_valid, fetch_valid&&predict_hit, update_valid, update_valid&&update_mispredict; each saturates at 32'hFFFF_FFFF and clears on reset.
REQ-031 Without BP_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset, then fetch 0x100 -> predict_hit=0, predict_direction=0, predict_pc=0x104.
REQ-033 Update pc=0x100 taken target=0x200, next cycle fetch 0x100 -> hit=1, direction=1, predict_pc=0x200; two not-taken updates -> direction=0, predict_pc=0x104.
REQ-034 Default params: allocate taken branches 0x000,0x040,0x080,0x0C0 (set 0), fetch 0x000, allocate 0x100 -> 0x040 evicted (miss), 0x000 still hits.
REQ-035 Same cycle fetch 0x100 and taken update 0x100 target 0x300 on empty predictor -> miss that cycle, hit with predict_pc=0x300 next cycle.
REQ-036 Four taken updates on one PC -> counter stops at STRONG_T; one not-taken -> WEAK_T, still predicts taken.
REQ-037 With BP_STATS_EN: 3 fetches (1 hit), 2 updates (1 mispredict) -> stat_lookups=3, stat_hits=1, stat_updates=2, stat_mispredicts=1; reset -> all 0.
